// File: rtl/alu_operand_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_ctrl_pkg
// Description : Shared constants and pipe-slot type for the EX-stage
//               operand-select controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_operand_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b11;

    // One in-flight instruction as seen by the hazard logic
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } pipe_slot_t;

endpackage
`default_nettype wire

// File: rtl/alu_operand_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_ctrl_if
// Description : ID-side handshake and EX-side select bundle of the
//               operand-select controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_ctrl_if
    import alu_operand_ctrl_pkg::*;
();

    logic                  id_valid;
    logic                  id_ready;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_use_rs;
    logic                  id_use_rt;
    logic                  id_alualtsrc;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  flush;
    logic                  ex_valid;
    logic                  ex_alualtsrc;
    logic [1:0]            ex_fwd_a;
    logic [1:0]            ex_fwd_b;
    logic                  stall;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_alualtsrc,
               id_rd, id_regwrite, id_memread, flush,
        input  id_ready, ex_valid, ex_alualtsrc, ex_fwd_a, ex_fwd_b, stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_alualtsrc,
               id_rd, id_regwrite, id_memread, flush,
        output id_ready, ex_valid, ex_alualtsrc, ex_fwd_a, ex_fwd_b, stall
    );

endinterface
`default_nettype wire

// File: rtl/alu_operand_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : alu_fwd_sel
// Description : Combinational forward-select and load-hazard detection for
//               one source operand against the EX and MEM slots.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_fwd_sel
    import alu_operand_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  use_src,
    input  pipe_slot_t            ex_slot,
    input  pipe_slot_t            mem_slot,
    output logic [1:0]            fwd_sel,
    output logic                  load_hazard
);

    logic ex_match;
    logic mem_match;
    logic unused_mem_memread;

    // The MEM-slot load has already produced its data, so its memread is irrelevant
    assign unused_mem_memread = mem_slot.memread;

    // Match producers; the zero register is never a real dependency
    always_comb begin
        ex_match  = ex_slot.valid  & ex_slot.regwrite  & (ex_slot.rd  == src)
                    & (src != ZERO_REG) & use_src;
        mem_match = mem_slot.valid & mem_slot.regwrite & (mem_slot.rd == src)
                    & (src != ZERO_REG) & use_src;
        if (ex_match) begin
            fwd_sel = FWD_EXMEM;
        end else if (mem_match) begin
            fwd_sel = FWD_MEMWB;
        end else begin
            fwd_sel = FWD_REG;
        end
        load_hazard = ex_match & ex_slot.memread;
    end

endmodule
`default_nettype wire

// File: rtl/alu_operand_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_ctrl
// Description : EX-stage operand-select controller. Tracks the EX and MEM
//               destination slots, registers operand-A immediate select and
//               forwarding selects for each accepted ID instruction, and
//               stalls ID on a load-use hazard.
//               Optional build macro ALU_OPERAND_CTRL_STATS_EN adds
//               stall/forward/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_ctrl
    import alu_operand_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
`ifdef ALU_OPERAND_CTRL_STATS_EN
    output logic [31:0]        stall_cnt,
    output logic [31:0]        fwd_cnt,
    output logic [31:0]        flush_cnt,
`endif
    alu_operand_ctrl_if.slave  bus
);

    pipe_slot_t ex_slot_q,  ex_slot_d;
    pipe_slot_t mem_slot_q, mem_slot_d;
    logic       ex_valid_q, ex_valid_d;
    logic       ex_alualtsrc_q, ex_alualtsrc_d;
    logic [1:0] ex_fwd_a_q, ex_fwd_a_d;
    logic [1:0] ex_fwd_b_q, ex_fwd_b_d;

    logic       w_use_rs;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_haz_a;
    logic       w_haz_b;
    logic       w_stall;
    logic       w_accept;

    // Operand A taken from the immediate does not read rs at all
    assign w_use_rs = bus.id_use_rs & ~bus.id_alualtsrc;

    alu_fwd_sel u_fwd_a (
        .src         (bus.id_rs),
        .use_src     (w_use_rs),
        .ex_slot     (ex_slot_q),
        .mem_slot    (mem_slot_q),
        .fwd_sel     (w_fwd_a),
        .load_hazard (w_haz_a)
    );

    alu_fwd_sel u_fwd_b (
        .src         (bus.id_rt),
        .use_src     (bus.id_use_rt),
        .ex_slot     (ex_slot_q),
        .mem_slot    (mem_slot_q),
        .fwd_sel     (w_fwd_b),
        .load_hazard (w_haz_b)
    );

    // Stall is reported even under flush; flush still wins for acceptance
    assign w_stall  = bus.id_valid & (w_haz_a | w_haz_b);
    assign w_accept = bus.id_valid & ~w_stall & ~bus.flush;

    assign bus.stall        = w_stall;
    assign bus.id_ready     = ~w_stall;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_alualtsrc = ex_alualtsrc_q;
    assign bus.ex_fwd_a     = ex_fwd_a_q;
    assign bus.ex_fwd_b     = ex_fwd_b_q;

    // Next slot contents and EX selects: bubble unless an instruction is accepted
    always_comb begin
        ex_slot_d      = '0;
        mem_slot_d     = ex_slot_q;
        ex_valid_d     = 1'b0;
        ex_alualtsrc_d = 1'b0;
        ex_fwd_a_d     = FWD_REG;
        ex_fwd_b_d     = FWD_REG;
        if (w_accept) begin
            ex_slot_d.valid    = 1'b1;
            ex_slot_d.rd       = bus.id_rd;
            ex_slot_d.regwrite = bus.id_regwrite;
            ex_slot_d.memread  = bus.id_memread;
            ex_valid_d         = 1'b1;
            ex_alualtsrc_d     = bus.id_alualtsrc;
            ex_fwd_a_d         = w_fwd_a;
            ex_fwd_b_d         = w_fwd_b;
        end
    end

    // Slot and EX-select registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot_q      <= '0;
            mem_slot_q     <= '0;
            ex_valid_q     <= 1'b0;
            ex_alualtsrc_q <= 1'b0;
            ex_fwd_a_q     <= FWD_REG;
            ex_fwd_b_q     <= FWD_REG;
        end else begin
            ex_slot_q      <= ex_slot_d;
            mem_slot_q     <= mem_slot_d;
            ex_valid_q     <= ex_valid_d;
            ex_alualtsrc_q <= ex_alualtsrc_d;
            ex_fwd_a_q     <= ex_fwd_a_d;
            ex_fwd_b_q     <= ex_fwd_b_d;
        end
    end

`ifdef ALU_OPERAND_CTRL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q,   fwd_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Event counters, wrapping naturally at 2^32
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_stall & ~bus.flush) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (w_accept & ((w_fwd_a != FWD_REG) | (w_fwd_b != FWD_REG))) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
        if (bus.flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_ctrl
// Description : Directed-vector scoreboard bench for alu_operand_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_ctrl;
    import alu_operand_ctrl_pkg::*;

    typedef struct packed {
        logic       stall;
        logic       ev;
        logic       alt;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t cur_e;
    exp_t prev_e;
    bit   have_prev = 1'b0;
    int   vec_no = 0;

    alu_operand_ctrl_if bus();

`ifdef ALU_OPERAND_CTRL_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
    logic [31:0] flush_cnt;
`endif

    alu_operand_ctrl dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ALU_OPERAND_CTRL_STATS_EN
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt),
        .flush_cnt (flush_cnt),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Drive one ID-cycle vector just after the clock edge and queue its expectation
    task automatic step(
        input logic v, input logic [4:0] rs, input logic [4:0] rt,
        input logic urs, input logic urt, input logic alt,
        input logic [4:0] rd, input logic rw, input logic mr, input logic fl,
        input logic e_stall, input logic e_ev, input logic e_alt,
        input logic [1:0] e_fa, input logic [1:0] e_fb);
        exp_t e;
        @(posedge clk);
        #1;
        bus.id_valid     = v;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_use_rs    = urs;
        bus.id_use_rt    = urt;
        bus.id_alualtsrc = alt;
        bus.id_rd        = rd;
        bus.id_regwrite  = rw;
        bus.id_memread   = mr;
        bus.flush        = fl;
        e.stall = e_stall;
        e.ev    = e_ev;
        e.alt   = e_alt;
        e.fa    = e_fa;
        e.fb    = e_fb;
        sb_q.push_back(e);
    endtask

    // Monitor: stall is checked in the cycle it is raised; EX selects one cycle later
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                cur_e = sb_q.pop_front();
                vec_no++;
                checks++;
                if (bus.stall !== cur_e.stall || bus.id_ready !== ~cur_e.stall) begin
                    errors++;
                    $display("FAIL stall vec%0d: got stall=%b id_ready=%b, expected stall=%b id_ready=%b",
                             vec_no, bus.stall, bus.id_ready, cur_e.stall, ~cur_e.stall);
                end
                if (have_prev) begin
                    checks++;
                    if (bus.ex_valid !== prev_e.ev || bus.ex_alualtsrc !== prev_e.alt ||
                        bus.ex_fwd_a !== prev_e.fa || bus.ex_fwd_b !== prev_e.fb) begin
                        errors++;
                        $display("FAIL ex vec%0d: got v=%b alt=%b fa=%b fb=%b, expected v=%b alt=%b fa=%b fb=%b",
                                 vec_no - 1, bus.ex_valid, bus.ex_alualtsrc, bus.ex_fwd_a, bus.ex_fwd_b,
                                 prev_e.ev, prev_e.alt, prev_e.fa, prev_e.fb);
                    end
                end
                prev_e    = cur_e;
                have_prev = 1'b1;
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0;
        bus.id_use_rt = 0; bus.id_alualtsrc = 0; bus.id_rd = 0;
        bus.id_regwrite = 0; bus.id_memread = 0; bus.flush = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_alualtsrc !== 1'b0 || bus.ex_fwd_a !== 2'b00 ||
            bus.ex_fwd_b !== 2'b00 || bus.id_ready !== 1'b1 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset: got v=%b alt=%b fa=%b fb=%b rdy=%b stall=%b, expected 0 0 00 00 1 0",
                     bus.ex_valid, bus.ex_alualtsrc, bus.ex_fwd_a, bus.ex_fwd_b, bus.id_ready, bus.stall);
        end

        //    v  rs  rt  urs urt alt rd  rw mr fl   stall ev alt fa     fb
        step(1,  1,  2,  1,  1,  0,  5,  1, 0, 0,   0,   1, 0, 2'b00, 2'b00); // add r5
        step(1,  5,  6,  1,  1,  0,  8,  1, 0, 0,   0,   1, 0, 2'b10, 2'b00); // back-to-back on rs
        step(1,  1,  2,  1,  1,  0,  9,  1, 0, 0,   0,   1, 0, 2'b00, 2'b00); // unrelated
        step(1,  8,  9,  1,  1,  0, 10,  1, 0, 0,   0,   1, 0, 2'b11, 2'b10); // distance 2 / 1
        step(1,  0,  0,  1,  1,  0, 10,  1, 0, 0,   0,   1, 0, 2'b00, 2'b00); // r10 again, r0 sources
        step(1, 10,  3,  1,  1,  0, 11,  1, 0, 0,   0,   1, 0, 2'b10, 2'b00); // newest producer wins
        step(1,  1,  0,  1,  0,  0,  7,  1, 1, 0,   0,   1, 0, 2'b00, 2'b00); // lw r7
        step(1,  7,  2,  1,  1,  0, 12,  1, 0, 0,   1,   0, 0, 2'b00, 2'b00); // load-use stall
        step(1,  7,  2,  1,  1,  0, 12,  1, 0, 0,   0,   1, 0, 2'b11, 2'b00); // released, MEM fwd
        step(1,  0,  0,  0,  0,  0,  5,  1, 1, 0,   0,   1, 0, 2'b00, 2'b00); // lw r5
        step(1,  5, 12,  1,  1,  1, 13,  1, 0, 0,   0,   1, 1, 2'b00, 2'b11); // immediate A, no stall
        step(1,  0,  0,  0,  0,  0,  7,  1, 1, 0,   0,   1, 0, 2'b00, 2'b00); // lw r7
        step(1,  7,  0,  1,  1,  0, 14,  1, 0, 1,   1,   0, 0, 2'b00, 2'b00); // flush in stall cycle
        step(1,  7,  0,  1,  1,  0, 14,  1, 0, 0,   0,   1, 0, 2'b11, 2'b00); // lw now in MEM
        step(1,  1,  2,  1,  1,  0,  0,  1, 0, 0,   0,   1, 0, 2'b00, 2'b00); // write r0
        step(1,  0, 14,  1,  1,  0, 15,  1, 0, 0,   0,   1, 0, 2'b00, 2'b11); // r0 never forwarded
        step(1,  0, 15,  1,  1,  0, 16,  1, 0, 0,   0,   1, 0, 2'b00, 2'b10); // r0 in MEM ignored
        step(1, 16, 16,  0,  0,  0, 17,  1, 0, 0,   0,   1, 0, 2'b00, 2'b00); // unused sources
        step(0, 17,  0,  1,  0,  0,  0,  0, 0, 0,   0,   0, 0, 2'b00, 2'b00); // no valid
        step(0,  0,  0,  0,  0,  0,  0,  0, 0, 0,   0,   0, 0, 2'b00, 2'b00); // drain

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb_q.size());
        end
`ifdef ALU_OPERAND_CTRL_STATS_EN
        checks++;
        if (stall_cnt !== 32'd1 || fwd_cnt !== 32'd8 || flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL stats: got stall=%0d fwd=%0d flush=%0d, expected 1 8 1",
                     stall_cnt, fwd_cnt, flush_cnt);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
